// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix 2^BITS_PER_CYCLE restoring, start/done handshake.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and divisor==1 bypass the iterations.
module div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      func,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            squash,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic c);
    return c ? (~x + XLEN'(1)) : x;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d, rem_n;
  logic [XLEN-1:0] quo_q, quo_d, quo_n;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic            rsel_q, rsel_d;
  logic            div0_q, div0_d, triv_q, triv_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic signed [XLEN-1:0] dvd_sgn, dvs_sgn;
  logic                   signed_op, dvd_neg, dvs_neg, is_div0, is_ovf, one_hit, early;
  logic [XLEN-1:0]        dvd_orig, q_out, r_out;

  assign dvd_sgn   = dividend;
  assign dvs_sgn   = divisor;
  assign signed_op = ~func[0];
  assign dvd_neg   = signed_op && (dvd_sgn < 0);
  assign dvs_neg   = signed_op && (dvs_sgn < 0);
  assign is_div0   = (divisor == '0);
  assign is_ovf    = signed_op && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
  assign one_hit = (divisor == XLEN'(1));
  assign early   = is_div0 | is_ovf | one_hit;
`else
  assign one_hit = 1'b0;
  assign early   = 1'b0;
`endif

  // One iteration: BITS_PER_CYCLE restoring steps on {remainder, quotient}
  always_comb begin
    rem_n = rem_q;
    quo_n = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_n = {rem_n[XLEN-1:0], quo_n[XLEN-1]};
      quo_n = {quo_n[XLEN-2:0], 1'b0};
      if (rem_n >= {1'b0, dvs_q}) begin
        rem_n    = rem_n - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
    end
  end

  // Sign fix-up; special cases override the iterated values
  always_comb begin
    dvd_orig = neg_if(dvd_q, r_neg_q);
    q_out    = neg_if(quo_q, q_neg_q);
    r_out    = neg_if(rem_q[XLEN-1:0], r_neg_q);
    if (div0_q) begin
      q_out = '1;
      r_out = dvd_orig;
    end else if (triv_q) begin
      q_out = dvd_orig;
      r_out = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    rsel_d   = rsel_q;
    div0_d   = div0_q;
    triv_d   = triv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !squash) begin
          dvd_d   = neg_if(dividend, dvd_neg);
          dvs_d   = neg_if(divisor, dvs_neg);
          rem_d   = '0;
          quo_d   = neg_if(dividend, dvd_neg);
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          rsel_d  = func[1];
          div0_d  = is_div0;
          triv_d  = is_ovf | one_hit;
          busy_d  = 1'b1;
          if (early) begin
            state_d = FIX;
            cnt_d   = '0;
          end else begin
            state_d = ITER;
            cnt_d   = CW'(N);
          end
        end
      end
      ITER: begin
        if (squash) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!squash) begin
          done_d   = 1'b1;
          result_d = rsel_q ? r_out : q_out;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rsel_q   <= 1'b0;
      div0_q   <= 1'b0;
      triv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      rsel_q   <= rsel_d;
      div0_q   <= div0_d;
      triv_q   <= triv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus randomized ops against an arithmetic reference model.
module tb_div_unit;
  localparam int N = 16;

  logic        clock = 1'b0;
  logic        reset, start, squash;
  logic [1:0]  func;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res;

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) dut (
    .clock(clock), .reset(reset), .start(start), .func(func),
    .dividend(dividend), .divisor(divisor), .squash(squash),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      2'b00:   if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return $signed(a) / $signed(b);
      2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'b10:   if (b == 0) return a; else if (ovf) return 32'h0; else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    fast = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    fast = (b == 0) || (b == 1) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`endif
    return fast ? 2 : N + 2;
  endfunction

  task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    func = f; dividend = a; divisor = b; start = 1'b1;
  endtask

  // Call with start already driven in cycle 0; observes cycles 1..40.
  task automatic track(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int extra_at, input int squash_at, input bit chain,
                       input logic [1:0] cf, input logic [31:0] ca, input logic [31:0] cb);
    int          got, bcnt, lat;
    logic [31:0] exp;
    bit          sq;
    got  = 0;
    bcnt = 0;
    lat  = lat_of(f, a, b);
    exp  = model(f, a, b);
    sq   = (squash_at >= 1) && (squash_at <= lat - 1);
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == extra_at + 1) start = 1'b0;
      if (c == squash_at + 1) squash = 1'b0;
      if (c == extra_at) begin
        start = 1'b1; func = 2'b01; dividend = ~a; divisor = 32'd3;
      end
      if (c == squash_at) squash = 1'b1;
      if (busy) bcnt++;
      if (done) begin
        got = c;
        break;
      end
    end
    if (sq) begin
      check32({tag, " nodone"}, got, 0);
      check32({tag, " res_hold"}, result, last_res);
    end else begin
      check32({tag, " latency"}, got, lat);
      check32({tag, " result"}, result, exp);
      check32({tag, " busy_cycles"}, bcnt, lat - 1);
      check32({tag, " busy_at_done"}, {31'b0, busy}, 0);
      last_res = exp;
      if (chain && got != 0) launch(cf, ca, cb);
    end
  endtask

  task automatic op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1 launch(f, a, b);
    track(tag, f, a, b, 0, 0, 1'b0, 2'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          extra;
    logic [1:0]  f;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; squash = 1'b0; func = 2'b0; dividend = '0; divisor = '0;
    last_res = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check32("rst busy", {31'b0, busy}, 0);
    check32("rst done", {31'b0, done}, 0);
    check32("rst result", result, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    op("divu100_7", 2'b01, 32'd100, 32'd7);
    op("remu100_7", 2'b11, 32'd100, 32'd7);
    op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    op("div7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE);
    op("divu5_0", 2'b01, 32'd5, 32'd0);
    op("rem5_0", 2'b10, 32'd5, 32'd0);
    op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    op("div_m9_1", 2'b00, 32'hFFFF_FFF7, 32'd1);

    // Squash mid-flight: no done, result held, then a normal op
    @(posedge clock);
    #1 launch(2'b01, 32'd1000, 32'd3);
    track("squash", 2'b01, 32'd1000, 32'd3, 0, 5, 1'b0, 2'b0, 32'h0, 32'h0);
    op("after_squash", 2'b01, 32'd9, 32'd3);

    // Second start while busy is ignored
    @(posedge clock);
    #1 launch(2'b01, 32'd1234, 32'd10);
    track("busy_start", 2'b01, 32'd1234, 32'd10, 4, 0, 1'b0, 2'b0, 32'h0, 32'h0);
    extra = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) extra++;
    end
    check32("no_extra_done", extra, 0);

    // Back-to-back: second start driven during the done cycle
    @(posedge clock);
    #1 launch(2'b01, 32'd100, 32'd7);
    track("b2b_first", 2'b01, 32'd100, 32'd7, 0, 0, 1'b1, 2'b01, 32'd50, 32'd5);
    track("b2b_second", 2'b01, 32'd50, 32'd5, 0, 0, 1'b0, 2'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-iteration
    @(posedge clock);
    #1 launch(2'b01, 32'd1000, 32'd3);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    check32("pre_rst busy", {31'b0, busy}, 1);
    reset = 1'b1;
    #1;
    check32("async_rst busy", {31'b0, busy}, 0);
    check32("async_rst done", {31'b0, done}, 0);
    check32("async_rst result", result, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    last_res = '0;
    op("after_rst", 2'b00, 32'd100, 32'hFFFF_FFF9);

    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3, 4:    b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      op("random", f, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative integer divider FU; the inverse-operation companion to the pipelined multiplier in the execute stage.
- Executes RV32M DIV, DIVU, REM and REMU, taking operands from the issue stage.
- Uses a start/done handshake and a busy flag so the RS stalls divide issue while an operation is in flight.
- Supports squash on branch mispredict.

Parameters:
- XLEN, 32: operand/result width.
- BITS_PER_CYCLE, 2: quotient bits retired per iteration. Legal values 1, 2, 4; must divide XLEN. N = XLEN/BITS_PER_CYCLE iterations.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  launch request; sampled at posedge.
- func  in  2  op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- dividend  in  XLEN  rs1 value.
- divisor  in  XLEN  rs2 value.
- squash  in  1  abort in-flight op.
- busy  out  1  op in flight; start ignored while high.
- done  out  1  one-cycle pulse, result valid.
- result  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); holds until next done.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs cleared. Any in-flight op is lost with no done. First accept is allowed on the first posedge after reset deasserts.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 and squash=0 -> ITER, counter=N.
  - Capture |dividend| and |divisor| (magnitudes only for signed funcs), the sign of the quotient, the sign of the remainder (= dividend sign), and func.
- ITER:
  - Each cycle performs BITS_PER_CYCLE restoring shift/subtract steps on {remainder, quotient}. Remainder width XLEN+1.
  - Decrement counter; at counter==1 go to FIX.
- FIX:
  - Apply sign correction (two's-complement negate quotient/remainder per captured signs).
  - Select the output per func and register it into result; done=1 for exactly one cycle; state -> IDLE.
- busy=1 in ITER and FIX; 0 in IDLE, including the done cycle.
- start may be high in the done cycle and is accepted, giving back-to-back ops.
- Latency: start sampled at the end of cycle 0; done high in cycle N+2. Default is 18 cycles.
- Special cases, per the RISC-V spec, decided at capture and held through the full latency (no early exit by default):
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend=100..0, divisor=all ones, DIV/REM): quotient = dividend; remainder = 0.
- Squash:
  - In ITER/FIX: next state IDLE, done stays 0, result unchanged.
  - Coincident with start in IDLE: start ignored.
  - Coincident with the FIX->done edge: done suppressed.
- start while busy: ignored, no effect on the in-flight op.
- Inputs other than start/squash are don't-care outside the accepting cycle.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero, signed overflow and divisor==1 skip ITER, going IDLE -> FIX directly. done appears in cycle 2 after start.
  - For divisor==1: quotient = dividend, remainder = 0.
- Undefined: all ops take the fixed N+2 latency; the divisor==1 path is not special.

Test Plan:
- DIVU 100 / 7, start in cycle 0 -> result=0x0000000E, done high exactly in cycle 18, busy high cycles 1-17. Then REMU 100 / 7 -> 0x00000002.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
- Divide by zero:
  - DIVU 5 / 0 -> 0xFFFFFFFF.
  - REM 5 / 0 -> 0x00000005.
  - With DIV_EARLY_OUT_EN, done arrives in cycle 2.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
- Squash: start DIVU 1000 / 3, squash in cycle 5 -> no done within 30 cycles. Next DIVU 9 / 3 -> 3 with normal latency.
- Reset and handshake:
  - Second start while busy (cycle 4) -> ignored; only the first result appears.
  - Back-to-back start in the done cycle -> second done exactly 18 cycles later.
  - Async reset asserted mid-ITER -> busy/done/result=0 immediately, without waiting for a clock edge.
